codificador_pt2262_burst: RTL and testbench

Parametrised PT2262-compatible serial encoder: N_ADDR trinary address symbols plus N_DATA binary data bits plus sync, emitted on cod_o as pulse-width-coded waveforms timed in oscillator units (α).
Successor to the fixed 8+4 encoder: configurable symbol counts and α divider, start/busy handshake, counted or continuous bursts, and graceful stop.
Sits between the keypad/address-switch logic and the RF modulator pin.

---
 rtl/pt2262_pkg.sv | 48 ++++
 rtl/pt2262_alpha_tick.sv | 32 +++
 rtl/codificador_pt2262_burst.sv | 186 ++++++++++++++++++
 tb/tb_codificador_pt2262_burst.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pt2262_pkg.sv
// Shared types, timing constants and symbol helpers for the PT2262-style encoder.
package pt2262_pkg;

    typedef enum logic [1:0] {SYM_0, SYM_1, SYM_F} sym_t;
    typedef enum logic [1:0] {IDLE, BIT, SYNC} state_t;

    // Symbol timing in oscillator units (alpha).
    localparam int ALPHA_BIT  = 32;
    localparam int ALPHA_SYNC = 128;
    localparam int SHORT_A    = 4;
    localparam int LONG_A     = 12;
    localparam int HALF_A     = ALPHA_BIT / 2;

    // The alpha counter must hold 0..ALPHA_SYNC-1.
    localparam int ALPHA_W = $clog2(ALPHA_SYNC);
    typedef logic [ALPHA_W-1:0] alpha_t;

    // Address switch code to symbol: 00 -> '0', 01 -> '1', 1x -> floating.
    function automatic sym_t addr_code_to_sym(input logic [1:0] code);
        case (code)
            2'b00:   return SYM_0;
            2'b01:   return SYM_1;
            default: return SYM_F;
        endcase
    endfunction

    // Output level of a data/address symbol at a given alpha position (0..31).
    // Each half is one high pulse followed by low; '1' uses long pulses in both
    // halves, 'F' only in the second half, '0' never.
    function automatic logic sym_level(input sym_t sym, input alpha_t alpha);
        logic   long_pulse;
        alpha_t pos;
        if (alpha < alpha_t'(HALF_A)) begin
            long_pulse = (sym == SYM_1);
            pos        = alpha;
        end else begin
            long_pulse = (sym != SYM_0);
            pos        = alpha - alpha_t'(HALF_A);
        end
        return long_pulse ? (pos < alpha_t'(LONG_A)) : (pos < alpha_t'(SHORT_A));
    endfunction

    // Sync symbol: one short pulse, then a long low tail.
    function automatic logic sync_level(input alpha_t alpha);
        return alpha < alpha_t'(SHORT_A);
    endfunction

endpackage

// File: rtl/pt2262_alpha_tick.sv
// Alpha-period divider: counts 0..CLK_DIV-1 and ticks on the last count.
// Held at zero while i_clear is high so each word starts phase-aligned.
module pt2262_alpha_tick #(
    parameter int CLK_DIV = 96
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(CLK_DIV - 1));
    assign o_tick = !i_clear && w_last;

    // Divider counter: wraps at CLK_DIV-1, forced to zero while cleared.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/codificador_pt2262_burst.sv
// PT2262-compatible serial encoder: N_ADDR trinary address symbols, N_DATA
// data bits and a sync symbol, sent as counted or continuous bursts.
module codificador_pt2262_burst
    import pt2262_pkg::*;
#(
    parameter int N_ADDR  = 8,
    parameter int N_DATA  = 4,
    parameter int CLK_DIV = 96,
    parameter int BURST_W = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [2*N_ADDR-1:0]                  addr_i,
    // With N_DATA = 0 a single unused bit keeps the port legal.
    input  logic [(N_DATA > 0 ? N_DATA : 1)-1:0] data_i,
    input  logic                                 start_i,
    input  logic                                 stop_i,
    input  logic [BURST_W-1:0]                   burst_i,
    output logic                                 busy_o,
    output logic                                 cod_o,
    output logic                                 sync_o,
    output logic                                 word_done_o
);

    localparam int N_SYM = N_ADDR + N_DATA;
    localparam int DW    = (N_DATA > 0) ? N_DATA : 1;
    localparam int IW    = (N_SYM > 1) ? $clog2(N_SYM) : 1;

    typedef logic [IW-1:0] idx_t;

    // Symbol at position idx of the latched word: address first, then data.
    function automatic sym_t symbol_at(input idx_t idx,
                                       input logic [2*N_ADDR-1:0] addr,
                                       input logic [DW-1:0] data);
        int k;
        k = int'(idx);
        if (k < N_ADDR) begin
            return addr_code_to_sym(2'(addr >> (2 * k)));
        end
        return (1'(data >> (k - N_ADDR))) ? SYM_1 : SYM_0;
    endfunction

    state_t                r_state,     w_state_nxt;
    idx_t                  r_idx,       w_idx_nxt;
    alpha_t                r_alpha,     w_alpha_nxt;
    logic [2*N_ADDR-1:0]   r_addr,      w_addr_nxt;
    logic [DW-1:0]         r_data,      w_data_nxt;
    logic [BURST_W-1:0]    r_remaining, w_rem_nxt;
    logic                  r_continuous, w_cont_nxt;
    logic                  r_stop_pend, w_stop_nxt;
    logic                  r_cod,  w_cod_nxt;
    logic                  r_sync;
    logic                  r_busy;
    logic                  w_word_done;
    logic                  w_tick;
    sym_t                  w_sym_nxt;

    pt2262_alpha_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_alpha_tick (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state == IDLE),
        .o_tick  (w_tick)
    );

    // Next-state logic: symbol/alpha sequencing, latching and burst decisions.
    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_alpha_nxt = r_alpha;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_rem_nxt   = r_remaining;
        w_cont_nxt  = r_continuous;
        w_stop_nxt  = r_stop_pend;
        w_word_done = 1'b0;

        case (r_state)
            IDLE: begin
                w_stop_nxt = 1'b0;
                if (start_i) begin
                    w_state_nxt = BIT;
                    w_idx_nxt   = '0;
                    w_alpha_nxt = '0;
                    w_addr_nxt  = addr_i;
                    w_data_nxt  = data_i;
                    w_rem_nxt   = burst_i;
                    w_cont_nxt  = (burst_i == '0);
                end
            end

            BIT: begin
                if (stop_i) w_stop_nxt = 1'b1;
                if (w_tick) begin
                    if (r_alpha == alpha_t'(ALPHA_BIT - 1)) begin
                        w_alpha_nxt = '0;
                        if (r_idx == idx_t'(N_SYM - 1)) begin
                            w_state_nxt = SYNC;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_alpha_nxt = r_alpha + 1'b1;
                    end
                end
            end

            SYNC: begin
                if (stop_i) w_stop_nxt = 1'b1;
                if (w_tick) begin
                    if (r_alpha == alpha_t'(ALPHA_SYNC - 1)) begin
                        w_word_done = 1'b1;
                        w_alpha_nxt = '0;
                        w_idx_nxt   = '0;
                        if (!r_continuous) w_rem_nxt = r_remaining - 1'b1;
                        if (w_stop_nxt ||
                            (!r_continuous && (w_rem_nxt == '0)) ||
                            (r_continuous && !start_i)) begin
                            w_state_nxt = IDLE;
                            w_stop_nxt  = 1'b0;
                        end else begin
                            // Back-to-back word: fresh address/data, no gap.
                            w_state_nxt = BIT;
                            w_addr_nxt  = addr_i;
                            w_data_nxt  = data_i;
                        end
                    end else begin
                        w_alpha_nxt = r_alpha + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output waveform level for the upcoming cycle, so cod_o is a clean flop.
    always_comb begin
        w_sym_nxt = symbol_at(w_idx_nxt, w_addr_nxt, w_data_nxt);
        w_cod_nxt = 1'b0;
        case (w_state_nxt)
            BIT:     w_cod_nxt = sym_level(w_sym_nxt, w_alpha_nxt);
            SYNC:    w_cod_nxt = sync_level(w_alpha_nxt);
            default: w_cod_nxt = 1'b0;
        endcase
    end

    // State, counters, input latches and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_alpha      <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_remaining  <= '0;
            r_continuous <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_cod        <= 1'b0;
            r_sync       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_alpha      <= w_alpha_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_remaining  <= w_rem_nxt;
            r_continuous <= w_cont_nxt;
            r_stop_pend  <= w_stop_nxt;
            r_cod        <= w_cod_nxt;
            r_sync       <= (w_state_nxt == SYNC);
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    assign busy_o      = r_busy;
    assign cod_o       = r_cod;
    assign sync_o      = r_sync;
    assign word_done_o = w_word_done;

endmodule

// File: tb/tb_codificador_pt2262_burst.sv
// Scoreboard bench for codificador_pt2262_burst (CLK_DIV = 4, 8 address + 4 data).
// Stimulus pushes the expected pulse pattern of every word it requests; the
// monitor measures each word on cod_o and checks it when word_done_o pulses.
module tb_codificador_pt2262_burst;

    localparam int N_ADDR    = 8;
    localparam int N_DATA    = 4;
    localparam int CLK_DIV   = 4;
    localparam int BURST_W   = 8;
    localparam int N_SYM     = N_ADDR + N_DATA;
    localparam int SYM_CLK   = 32 * CLK_DIV;               // 128
    localparam int HALF_CLK  = SYM_CLK / 2;                // 64
    localparam int SHORT_CLK = 4 * CLK_DIV;                // 16
    localparam int LONG_CLK  = 12 * CLK_DIV;               // 48
    localparam int SYNC_CLK  = 128 * CLK_DIV;              // 512
    localparam int WORD_CLK  = N_SYM * SYM_CLK + SYNC_CLK; // 2048

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [2*N_ADDR-1:0] addr_i = '0;
    logic [N_DATA-1:0]  data_i = '0;
    logic               start_i = 1'b0;
    logic               stop_i = 1'b0;
    logic [BURST_W-1:0] burst_i = '0;
    logic               busy_o, cod_o, sync_o, word_done_o;

    int total = 0;
    int bad = 0;
    int wd_count = 0;
    logic [2*N_SYM-1:0] exp_q[$];

    codificador_pt2262_burst #(
        .N_ADDR  (N_ADDR),
        .N_DATA  (N_DATA),
        .CLK_DIV (CLK_DIV),
        .BURST_W (BURST_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .burst_i     (burst_i),
        .busy_o      (busy_o),
        .cod_o       (cod_o),
        .sync_o      (sync_o),
        .word_done_o (word_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Long/short flag per high pulse (2 per symbol): '0' = 00, '1' = 11,
    // 'F' = short then long (bit 2k = 0, bit 2k+1 = 1).
    function automatic logic [2*N_SYM-1:0] word_pattern(input logic [2*N_ADDR-1:0] a,
                                                         input logic [N_DATA-1:0] d);
        logic [2*N_SYM-1:0] p;
        logic [1:0] c;
        p = '0;
        for (int k = 0; k < N_ADDR; k++) begin
            c = 2'(a >> (2 * k));
            case (c)
                2'b00:   p = p;
                2'b01:   p = p | ((2*N_SYM)'(2'b11) << (2 * k));
                default: p = p | ((2*N_SYM)'(2'b10) << (2 * k));
            endcase
        end
        for (int j = 0; j < N_DATA; j++) begin
            if (1'(d >> j)) p = p | ((2*N_SYM)'(2'b11) << (2 * (N_ADDR + j)));
        end
        return p;
    endfunction

    // Monitor: measures each word and checks it against the scoreboard.
    initial begin : monitor
        bit in_word;
        bit prev_cod;
        int off, pstart, pidx, width, shape_err, sync_cnt;
        logic [2*N_SYM-1:0] lbits;
        logic [2*N_SYM-1:0] exp_word;
        in_word = 0; prev_cod = 0; off = 0; pstart = 0; pidx = 0;
        width = 0; shape_err = 0; sync_cnt = 0; lbits = '0;
        forever begin
            @(negedge clk);
            if (busy_o !== 1'b1) begin
                in_word = 0;
            end else begin
                if (!in_word) begin
                    in_word = 1; off = 0; prev_cod = 0; pidx = 0;
                    lbits = '0; shape_err = 0; sync_cnt = 0;
                end
                if (cod_o && !prev_cod) pstart = off;
                if (!cod_o && prev_cod) begin
                    width = off - pstart;
                    if (pidx < 2 * N_SYM) begin
                        if (pstart != pidx * HALF_CLK) shape_err++;
                        if (width == LONG_CLK) lbits = lbits | ((2*N_SYM)'(1) << pidx);
                        else if (width != SHORT_CLK) shape_err++;
                    end else if (pidx == 2 * N_SYM) begin
                        if (pstart != N_SYM * SYM_CLK || width != SHORT_CLK) shape_err++;
                    end else begin
                        shape_err++;
                    end
                    pidx++;
                end
                prev_cod = cod_o;
                if (sync_o) sync_cnt++;
                if (word_done_o) begin
                    wd_count++;
                    check("word_len", off + 1, WORD_CLK);
                    check("word_pulses", pidx, 2 * N_SYM + 1);
                    check("word_shape_errors", shape_err, 0);
                    check("word_sync_len", sync_cnt, SYNC_CLK);
                    check("word_expected_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_word = exp_q.pop_front();
                        check("word_pattern", lbits, exp_word);
                    end
                    in_word = 0;
                end
                off++;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Start a word: inputs set just after an edge, start_i captured on the next.
    task automatic launch(input logic [2*N_ADDR-1:0] a, input logic [N_DATA-1:0] d,
                          input logic [BURST_W-1:0] b);
        @(posedge clk); #1;
        addr_i = a; data_i = d; burst_i = b; start_i = 1'b1;
        @(posedge clk); #1;
    endtask

    // Count busy cycles until busy_o falls, bounded by budget.
    task automatic measure_busy(input string name, input int budget, output int cyc);
        int n;
        n = 0; cyc = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (busy_o === 1'b1) cyc++;
            else if (cyc > 0) break;
        end
        check({name, "_idle_in_budget"}, busy_o, 0);
    endtask

    localparam logic [2*N_ADDR-1:0] ADDR_MIX = 16'h2D24; // 0,1,F,0,1,F,F,0

    initial begin : stimulus
        int cyc, base;

        // Reset state
        #23;
        check("reset_busy", busy_o, 0);
        check("reset_cod", cod_o, 0);
        check("reset_sync", sync_o, 0);
        check("reset_word_done", word_done_o, 0);
        @(negedge clk); reset = 1'b1;

        // Single word, hand-computed pattern
        base = wd_count;
        exp_q.push_back(24'h0F2B2C);
        @(posedge clk); #1;
        addr_i = ADDR_MIX; data_i = 4'b0011; burst_i = 8'd1; start_i = 1'b1;
        @(negedge clk);
        check("busy_before_edge", busy_o, 0);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("busy_latency", busy_o, 1);
        check("cod_first_edge", cod_o, 1);
        measure_busy("single", 3000, cyc);
        check("single_busy_len", cyc, WORD_CLK);
        check("single_words", wd_count - base, 1);
        check("idle_cod", cod_o, 0);
        check("idle_sync", sync_o, 0);

        // Counted burst of 3, back-to-back
        repeat (10) @(posedge clk);
        base = wd_count;
        repeat (3) exp_q.push_back(word_pattern(16'hFFFF, 4'b1010));
        launch(16'hFFFF, 4'b1010, 8'd3);
        start_i = 1'b0;
        measure_busy("burst3", 7000, cyc);
        check("burst3_busy_len", cyc, 3 * WORD_CLK);
        check("burst3_words", wd_count - base, 3);

        // Continuous, start dropped in the middle of word 2
        repeat (10) @(posedge clk);
        base = wd_count;
        repeat (2) exp_q.push_back(word_pattern(16'h5555, 4'b0000));
        launch(16'h5555, 4'b0000, 8'd0);
        fork
            measure_busy("cont", 7000, cyc);
            begin
                repeat (WORD_CLK + 500) @(posedge clk);
                #1 start_i = 1'b0;
            end
        join
        check("cont_busy_len", cyc, 2 * WORD_CLK);
        check("cont_words", wd_count - base, 2);

        // Burst of 5 with stop during bit 6 of word 1
        repeat (10) @(posedge clk);
        base = wd_count;
        exp_q.push_back(word_pattern(16'h1B1B, 4'b0101));
        launch(16'h1B1B, 4'b0101, 8'd5);
        start_i = 1'b0;
        fork
            measure_busy("stop", 7000, cyc);
            begin
                repeat (6 * SYM_CLK + 40) @(posedge clk);
                #1 stop_i = 1'b1;
                @(posedge clk);
                #1 stop_i = 1'b0;
            end
        join
        check("stop_busy_len", cyc, WORD_CLK);
        check("stop_words", wd_count - base, 1);

        // Normal start after a stop
        repeat (20) @(posedge clk);
        base = wd_count;
        exp_q.push_back(word_pattern(16'h1B1B, 4'b0101));
        launch(16'h1B1B, 4'b0101, 8'd1);
        start_i = 1'b0;
        measure_busy("after_stop", 3000, cyc);
        check("after_stop_busy_len", cyc, WORD_CLK);
        check("after_stop_words", wd_count - base, 1);

        // data_i changes mid-word in continuous mode
        repeat (10) @(posedge clk);
        base = wd_count;
        exp_q.push_back(word_pattern(ADDR_MIX, 4'b0011));
        exp_q.push_back(word_pattern(ADDR_MIX, 4'b1100));
        launch(ADDR_MIX, 4'b0011, 8'd0);
        fork
            measure_busy("datachg", 7000, cyc);
            begin
                repeat (1199) @(posedge clk);
                #1 data_i = 4'b1100;
                repeat (1148) @(posedge clk);
                #1 start_i = 1'b0;
            end
        join
        check("datachg_busy_len", cyc, 2 * WORD_CLK);
        check("datachg_words", wd_count - base, 2);

        // Asynchronous reset mid-bit, then a fresh word from A0
        repeat (10) @(posedge clk);
        launch(ADDR_MIX, 4'b0011, 8'd1);
        start_i = 1'b0;
        repeat (300) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("abort_cod", cod_o, 0);
        check("abort_sync", sync_o, 0);
        check("abort_busy", busy_o, 0);
        repeat (3) @(posedge clk);
        base = wd_count;
        exp_q.push_back(word_pattern(ADDR_MIX, 4'b1100));
        #1;
        data_i = 4'b1100; burst_i = 8'd1; start_i = 1'b1;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("restart_busy", busy_o, 1);
        check("restart_cod", cod_o, 1);
        measure_busy("restart", 3000, cyc);
        check("restart_busy_len", cyc, WORD_CLK);
        check("restart_words", wd_count - base, 1);

        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("word_done_total", wd_count, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
